// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 accumulator sequencer: op codes, FSM encodings,
// flag bit positions and the sign-magnitude to two's-complement helper.
package alu4_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EXEC  = 2'b01,
        S_WRITE = 2'b10,
        S_HOLD  = 2'b11
    } state_e;

    localparam int FLG_C = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    // A magnitude of 4'b1000 with the sign set maps onto -8 without any special case.
    function automatic logic [3:0] sm_to_tc(input logic neg, input logic [3:0] mag);
        return neg ? (~mag + 4'd1) : mag;
    endfunction

endpackage

// File: rtl/alu4_acc_seq_if.sv
// Command and result handshake bundle of the accumulator sequencer.
interface alu4_acc_seq_if;
    import alu4_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    op_e        cmd_op;
    logic [3:0] cmd_operand;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [2:0] res_flags;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_operand, res_ready,
        input  cmd_ready, res_valid, res_data, res_flags
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_operand, res_ready,
        output cmd_ready, res_valid, res_data, res_flags
    );

endinterface

// File: rtl/alu4.sv
// 4-bit signed ALU: sign-magnitude result, carry flags a result outside -8..7.
module alu4
    import alu4_pkg::*;
(
    input  logic [3:0] n1,
    input  logic [3:0] n2,
    input  logic [1:0] op,
    output logic [3:0] out,
    output logic       carryf,
    output logic       zerof,
    output logic       negativef
);

    op_e        op_sel;
    logic [4:0] full;
    logic [4:0] mag;

    assign op_sel = op_e'(op);

    // Work in 5-bit signed so the true sign survives an overflow.
    always_comb begin
        full = 5'd0;
        case (op_sel)
            OP_AND:  full = {n1[3] & n2[3], n1 & n2};
            OP_OR:   full = {n1[3] | n2[3], n1 | n2};
            OP_ADD:  full = {n1[3], n1} + {n2[3], n2};
            OP_SUB:  full = {n1[3], n1} - {n2[3], n2};
            default: full = 5'd0;
        endcase
        mag = full[4] ? (~full + 5'd1) : full;
    end

    assign out       = mag[3:0];
    assign carryf    = full[4] ^ full[3];
    assign zerof     = (full == 5'd0);
    assign negativef = full[4];

endmodule

// File: rtl/alu4_acc_seq_sat_counter.sv
// Saturating event counter; holds at all-ones until cleared.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/alu4_acc_seq.sv
// Accumulator sequencer in front of alu4: takes commands, runs them through the ALU,
// and hands each accumulator result downstream over a valid/ready handshake.
module alu4_acc_seq
    import alu4_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    alu4_acc_seq_if.slave    bus,
    output logic [3:0]       alu_n1,
    output logic [3:0]       alu_n2,
    output logic [1:0]       alu_op,
    input  logic [3:0]       alu_out,
    input  logic             alu_carryf,
    input  logic             alu_zerof,
    input  logic             alu_negativef,
    output logic [CNT_W-1:0] carry_cnt
);

    state_e     state_reg;
    state_e     state_next;
    logic [3:0] acc_reg;
    logic [3:0] operand_reg;
    logic [2:0] flags_reg;
    op_e        op_reg;
    logic       load_reg;
    logic       carry_inc;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.cmd_valid) state_next = bus.cmd_load ? S_WRITE : S_EXEC;
            S_EXEC:  state_next = S_WRITE;
            S_WRITE: state_next = S_HOLD;
            S_HOLD:  if (bus.res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            acc_reg     <= 4'd0;
            operand_reg <= 4'd0;
            flags_reg   <= 3'b000;
            op_reg      <= OP_AND;
            load_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_IDLE) && bus.cmd_valid) begin
                op_reg      <= bus.cmd_op;
                operand_reg <= bus.cmd_operand;
                load_reg    <= bus.cmd_load;
            end
            if (state_reg == S_WRITE) begin
                if (load_reg) begin
                    acc_reg          <= operand_reg;
                    flags_reg[FLG_C] <= 1'b0;
                    flags_reg[FLG_Z] <= (operand_reg == 4'd0);
                    flags_reg[FLG_N] <= operand_reg[3];
                end else begin
                    acc_reg          <= sm_to_tc(alu_negativef, alu_out);
                    flags_reg[FLG_C] <= alu_carryf;
                    flags_reg[FLG_Z] <= alu_zerof;
                    flags_reg[FLG_N] <= alu_negativef;
                end
            end
        end
    end

    // ALU operands come straight from registers so the ALU sees a full cycle of settle.
    assign alu_n1 = acc_reg;
    assign alu_n2 = operand_reg;
    assign alu_op = op_reg;

    assign bus.cmd_ready = (state_reg == S_IDLE);
    assign bus.res_valid = (state_reg == S_HOLD);
    assign bus.res_data  = acc_reg;
    assign bus.res_flags = flags_reg;

    assign carry_inc = (state_reg == S_WRITE) && !load_reg && alu_carryf;

    sat_counter #(
        .W (CNT_W)
    ) u_carry_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (carry_inc),
        .count (carry_cnt)
    );

endmodule

// File: tb/tb_alu4_acc_seq.sv
// Scoreboard bench for alu4_acc_seq with alu4 closing the ALU loop.
module tb_alu4_acc_seq;
    import alu4_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_n1, alu_n2, alu_out;
    logic [1:0] alu_op;
    logic       alu_carryf, alu_zerof, alu_negativef;
    logic [7:0] carry_cnt;

    always #5 clk = ~clk;

    alu4_acc_seq_if bus();

    alu4_acc_seq #(.CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .alu_n1        (alu_n1),
        .alu_n2        (alu_n2),
        .alu_op        (alu_op),
        .alu_out       (alu_out),
        .alu_carryf    (alu_carryf),
        .alu_zerof     (alu_zerof),
        .alu_negativef (alu_negativef),
        .carry_cnt     (carry_cnt)
    );

    alu4 u_alu (
        .n1        (alu_n1),
        .n2        (alu_n2),
        .op        (alu_op),
        .out       (alu_out),
        .carryf    (alu_carryf),
        .zerof     (alu_zerof),
        .negativef (alu_negativef)
    );

    typedef struct {
        logic [3:0] data;
        logic [2:0] flags;
        int         lat;
        int         t;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [3:0] m_acc = 4'd0;
    int         m_cnt = 0;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d", tag, act);
        end
    endtask

    function automatic int sx(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Result monitor: latency on the rising edge of res_valid, data/flags on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus.res_valid && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
                else chk({sb[0].tag, "_lat"}, cyc - sb[0].t, sb[0].lat);
            end
            if (bus.res_valid && bus.res_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "_data"}, bus.res_data, e.data);
                chk({e.tag, "_flags"}, bus.res_flags, e.flags);
            end
            prev_valid <= bus.res_valid;
        end
    end

    // Call only just after a rising edge; returns 1 ns after the accepting edge.
    task automatic issue(input logic ld, input op_e op, input logic [3:0] opnd,
                         input string tag, input bit track, output int acc_t);
        exp_t e;
        int   r;
        int   n;
        logic c;
        n = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_load    = ld;
        bus.cmd_op      = op;
        bus.cmd_operand = opnd;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) chk({tag, "_ready_timeout"}, 0, 1);
        acc_t = cyc + 1;
        if (track) begin
            if (ld) begin
                e.data  = opnd;
                e.flags = {1'b0, opnd == 4'd0, opnd[3]};
                e.lat   = 1;
            end else begin
                case (op)
                    OP_AND:  r = sx(m_acc & opnd);
                    OP_OR:   r = sx(m_acc | opnd);
                    OP_ADD:  r = sx(m_acc) + sx(opnd);
                    default: r = sx(m_acc) - sx(opnd);
                endcase
                c       = (r > 7) || (r < -8);
                e.data  = 4'(r);
                e.flags = {c, r == 0, r < 0};
                e.lat   = 2;
                if (c && m_cnt < 255) m_cnt++;
            end
            e.t   = acc_t;
            e.tag = tag;
            m_acc = e.data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Wait for all expected results; ends just after a rising edge.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk({tag, "_drain_timeout"}, sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, h, n;
        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_load    = 1'b0;
        bus.cmd_op      = OP_AND;
        bus.cmd_operand = 4'd0;
        bus.res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_flags", bus.res_flags, 0);
        chk("rst_carry_cnt", carry_cnt, 0);
        @(posedge clk);
        #1;

        issue(1'b1, OP_ADD, 4'b0011, "t1_ld3", 1'b1, t);
        drain("t1");

        issue(1'b1, OP_ADD, 4'd5, "t2_ld5", 1'b1, t);
        issue(1'b0, OP_ADD, 4'b1101, "t2_add_m3", 1'b1, t);
        drain("t2");

        issue(1'b1, OP_ADD, 4'd7, "t3_ld7", 1'b1, t);
        issue(1'b0, OP_ADD, 4'd1, "t3_add_ovf", 1'b1, t);
        drain("t3");
        chk("t3_carry_cnt", carry_cnt, m_cnt);

        issue(1'b1, OP_ADD, 4'd2, "t4_ld2", 1'b1, t);
        issue(1'b0, OP_SUB, 4'd5, "t4_sub5", 1'b1, t);
        issue(1'b0, OP_SUB, 4'b1101, "t4_sub_m3", 1'b1, t);
        issue(1'b0, OP_OR, 4'b0110, "t4_or", 1'b1, t);
        issue(1'b0, OP_AND, 4'b1100, "t4_and", 1'b1, t);
        drain("t4");

        // Downstream stall with a new command waiting upstream
        bus.res_ready = 1'b0;
        issue(1'b1, OP_ADD, 4'd6, "t5_ld6", 1'b1, t);
        bus.cmd_valid   = 1'b1;
        bus.cmd_load    = 1'b1;
        bus.cmd_operand = 4'd9;
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_valid_seen", bus.res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t5_stall_ready", bus.cmd_ready, 0);
            chk("t5_stall_data", bus.res_data, 6);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        h = cyc + 1;
        issue(1'b1, OP_ADD, 4'd9, "t5_ld9", 1'b1, t2);
        chk("t5_accept_edge", t2, h + 1);
        drain("t5");

        // Saturation of the carry-event counter
        for (int i = 0; i < 300; i++) begin
            issue(1'b1, OP_ADD, 4'd7, "t6_ld7", 1'b1, t);
            issue(1'b0, OP_ADD, 4'd1, "t6_ovf", 1'b1, t);
        end
        drain("t6");
        chk("t6_carry_sat", carry_cnt, m_cnt);

        // Reset while the ADD is in EXEC: result must be dropped
        issue(1'b0, OP_ADD, 4'd1, "t6_abort", 1'b0, t);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_acc = 4'd0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_abort_no_valid", bus.res_valid, 0);
        end
        chk("t6_abort_ready", bus.cmd_ready, 1);
        chk("t6_abort_acc", bus.res_data, 0);
        chk("t6_abort_cnt", carry_cnt, m_cnt);
        @(posedge clk);
        #1;

        issue(1'b0, OP_ADD, 4'b1000, "t7_add_m8", 1'b1, t);
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
